// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port arbiter bus.
// Groups the writeback request, the MDU result and issue handshake, the pending
// scoreboard, the register file write port and the FIFO occupancy.
//   master : writeback stage / MDU / hazard unit side (drives the *_i signals)
//   slave  : rf_write_arbiter (drives the *_o signals)
interface rf_write_arbiter_if #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            wb_wr_en_i;
    logic [4:0]      wb_idx_i;
    logic [XLEN-1:0] wb_data_i;
    logic            wb_stall_o;

    logic            mdu_valid_i;
    logic            mdu_ready_o;
    logic [4:0]      mdu_idx_i;
    logic [XLEN-1:0] mdu_data_i;
    logic            mdu_issue_i;
    logic [4:0]      mdu_issue_idx_i;
    logic [31:0]     pending_o;

    logic            rf_wr_en_o;
    logic [4:0]      rf_idx_o;
    logic [XLEN-1:0] rf_data_o;
    logic [CW-1:0]   fifo_count_o;

    modport master (
        output wb_wr_en_i, wb_idx_i, wb_data_i,
        output mdu_valid_i, mdu_idx_i, mdu_data_i, mdu_issue_i, mdu_issue_idx_i,
        input  wb_stall_o, mdu_ready_o, pending_o,
        input  rf_wr_en_o, rf_idx_o, rf_data_o, fifo_count_o
    );

    modport slave (
        input  wb_wr_en_i, wb_idx_i, wb_data_i,
        input  mdu_valid_i, mdu_idx_i, mdu_data_i, mdu_issue_i, mdu_issue_idx_i,
        output wb_stall_o, mdu_ready_o, pending_o,
        output rf_wr_en_o, rf_idx_o, rf_data_o, fifo_count_o
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between writeback and the MDU.
// Writeback has priority; MDU results wait in a small FIFO and drain on idle
// writeback cycles. A starvation counter forces a one-cycle writeback stall so
// the FIFO head always drains. A pending scoreboard marks destinations of
// in-flight MDU ops for the hazard unit.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : rf_write_arbiter_if slave (writeback, MDU, scoreboard, RF port)
module rf_write_arbiter #(
    parameter int XLEN         = 64,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rf_write_arbiter_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]      idx_mem_q  [FIFO_DEPTH];
    logic [4:0]      idx_mem_d  [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem_q [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     pending_q, pending_d;

    logic            fifo_empty;
    logic            stall;
    logic            ready;
    logic            wb_win;
    logic            pop;
    logic            push;
    logic [4:0]      head_idx;
    logic [XLEN-1:0] head_data;

    // Grant decode. Everything is gated by rst_i so no write, push or stall
    // happens in a reset cycle, whatever state the flops hold.
    always_comb begin
        fifo_empty = (count_q == '0);
        head_idx   = idx_mem_q[rd_ptr_q];
        head_data  = data_mem_q[rd_ptr_q];
        stall      = !rst_i && !fifo_empty && (starve_q == LIMIT_C);
        ready      = !rst_i && (count_q < DEPTH_C);
        wb_win     = !rst_i && !stall && bus.wb_wr_en_i;
        pop        = !rst_i && !wb_win && !fifo_empty;
        push       = bus.mdu_valid_i && ready;
    end

    always_comb begin
        idx_mem_d  = idx_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        pending_d  = pending_q;

        if (push) begin
            idx_mem_d[wr_ptr_q]  = bus.mdu_idx_i;
            data_mem_d[wr_ptr_q] = bus.mdu_data_i;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d            = rd_ptr_q + PW'(1);
            pending_d[head_idx] = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Any cycle the head is not beaten by writeback it pops, so the
        // counter only survives consecutive writeback wins.
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (wb_win && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + SW'(1);
        end

        // Set after clear so a same-cycle issue to the popped index wins.
        if (bus.mdu_issue_i) begin
            pending_d[bus.mdu_issue_idx_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        bus.rf_wr_en_o = 1'b0;
        bus.rf_idx_o   = '0;
        bus.rf_data_o  = '0;
        if (wb_win) begin
            bus.rf_wr_en_o = (bus.wb_idx_i != 5'd0);
            bus.rf_idx_o   = bus.wb_idx_i;
            bus.rf_data_o  = bus.wb_data_i;
        end else if (pop) begin
            bus.rf_wr_en_o = (head_idx != 5'd0);
            bus.rf_idx_o   = head_idx;
            bus.rf_data_o  = head_data;
        end
        bus.wb_stall_o   = stall;
        bus.mdu_ready_o  = ready;
        bus.pending_o    = pending_q;
        bus.fifo_count_o = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
        end
        // Entry storage needs no reset; occupancy is tracked by count_q.
        idx_mem_q  <= idx_mem_d;
        data_mem_q <= data_mem_d;
    end
endmodule
